fsm_vedacao: RTL
================

# fsm_vedacao

Slave FSM for the sealing (vedação) station. It answers the master sequencer's `cmd_vedar` request by driving the sealing actuator for a fixed time and returning `vedacao_concluida`. It owns the cork (rolha) stock counter, which is decremented per sealed bottle and replenished by an operator refill pulse. It raises `alarme_rolha`, which the master uses to pause the line.

## Interface
Parameters:
- `TEMPO_VEDACAO`, default 25000000: actuator-on duration in clk cycles (0.5 s at 50 MHz); legal range 1..2^26-1.
- `ROLHAS_INICIAL`, default 10: stock value loaded at reset; must be ≤ ROLHAS_MAX.
- `ROLHAS_MAX`, default 99: saturation ceiling of the stock; must be ≤ 127.
- `RECARGA_QTD`, default 5: corks added per refill pulse.
- `LIMIAR_BAIXO`, default 2: low-stock warning threshold.

Ports:
- `clk`  input  1  50 MHz system clock.
- `reset`  input  1  reset, synchronous, active-low (one clock; reset synchronous active-low).
- `cmd_vedar`  input  1  level request from the master; held high until it sees `vedacao_concluida`.
- `recarga`  input  1  single-cycle refill pulse (already edge-detected upstream).
- `vedacao_concluida`  output  1  completion level; held until `cmd_vedar` drops.
- `atuador_vedacao`  output  1  sealing actuator / LED; high only while sealing.
- `alarme_rolha`  output  1  high when stock == 0.
- `alerta_baixo`  output  1  high when 0 < stock ≤ LIMIAR_BAIXO.
- `contagem_rolhas`  output  7  current stock, for the 7-seg display.

## Operation
- Registered state: `estado` (IDLE, SEM_ROLHA, VEDANDO, CONCLUIDO), `timer[25:0]`, `estoque[6:0]`. All outputs are decoded from registers only (Moore).
- IDLE: all action outputs 0.
  - `cmd_vedar`=1 and estoque>0: go to VEDANDO, timer←0.
  - `cmd_vedar`=1 and estoque==0: go to SEM_ROLHA.
- SEM_ROLHA: actuator off, concluida 0.
  - estoque>0 (refill arrived): go to VEDANDO, timer←0.
  - `cmd_vedar`=0: go to IDLE (abort). The abort check has priority.
- VEDANDO: `atuador_vedacao`=1, timer increments every cycle.
  - When timer == TEMPO_VEDACAO-1: go to CONCLUIDO and decrement estoque by 1 on that same edge.
  - If `cmd_vedar` drops first: go to IDLE with no decrement and timer←0.
- CONCLUIDO: `vedacao_concluida`=1, actuator off.
  - `cmd_vedar`=0: go to IDLE.
  - A request still high does not restart sealing.
- Stock update each cycle: next = min(estoque − dec + (recarga ? RECARGA_QTD : 0), ROLHAS_MAX).
  - Computed in 8 bits, then saturated.
  - dec is only possible when estoque ≥ 1, so no underflow.
  - Simultaneous refill and decrement both apply.
- `alarme_rolha` = (estoque==0). `alerta_baixo` = (estoque≠0 && estoque≤LIMIAR_BAIXO). `contagem_rolhas` = estoque.
- Illegal state encodings go to IDLE on the next edge.

## Timing
- Reset (`reset`=0 at an edge) results:
  - estado=IDLE, timer=0, estoque=ROLHAS_INICIAL.
  - concluida=0, atuador=0, contagem=ROLHAS_INICIAL.
  - alarme=(ROLHAS_INICIAL==0).
- Reset mid-sealing discards the operation and restores ROLHAS_INICIAL, with no partial decrement.
- Request latency: if `cmd_vedar` is sampled high at edge E (stock>0), the actuator is high from E through E+TEMPO_VEDACAO.
  - Concluida rises at edge E+TEMPO_VEDACAO and the stock drops at that same edge.
  - The actuator is high for exactly TEMPO_VEDACAO cycles.
- Release: if `cmd_vedar` is sampled low at edge F in CONCLUIDO, concluida falls at F. The earliest next acceptance is edge F+1.
- Refill: estoque and alarm/alert update at the edge that samples `recarga`. SEM_ROLHA→VEDANDO occurs at the following edge.
- With the master's behaviour, alarm low→high occurs at the completion edge of the last cork. The master sees it in its next checking state.

## Test plan
- TEMPO_VEDACAO=4, ROLHAS_INICIAL=2, ROLHAS_MAX=9, RECARGA_QTD=5:
  - Hold cmd high until concluida, then drop it.
  - Expect actuator high for exactly 4 cycles, then concluida=1, contagem 2→1, alerta_baixo=1.
  - Expect concluida to fall at the edge that samples cmd low.
- Two full cycles from stock 2:
  - Expect contagem=0 and alarme_rolha=1.
  - A third cmd goes to SEM_ROLHA with actuator 0 for 20 cycles.
  - A recarga pulse gives contagem=5, alarm=0, the actuator rises next edge, and the cycle completes with contagem=4.
- Stock 8, recarga pulse: contagem saturates at 9. A recarga asserted on the same edge as a completion at stock 9 gives 9.
- cmd dropped on the 2nd VEDANDO cycle: actuator falls, returns to IDLE, concluida never asserts, contagem unchanged.
- Reset asserted while in VEDANDO: the next cycle shows IDLE, actuator=0, concluida=0, contagem=ROLHAS_INICIAL.
- cmd held high after concluida for 10 cycles: concluida stays 1, actuator stays 0, only one decrement.

Source files
------------

// File: rtl/fsm_vedacao_if.sv
// Handshake and status bundle between the master sequencer and the sealing station.
// The master drives the request and refill pulse; the station returns completion and stock status.
interface fsm_vedacao_if;
   logic       cmd_vedar;
   logic       recarga;
   logic       vedacao_concluida;
   logic       atuador_vedacao;
   logic       alarme_rolha;
   logic       alerta_baixo;
   logic [6:0] contagem_rolhas;

   modport master (
      output cmd_vedar,
      output recarga,
      input  vedacao_concluida,
      input  atuador_vedacao,
      input  alarme_rolha,
      input  alerta_baixo,
      input  contagem_rolhas
   );

   modport slave (
      input  cmd_vedar,
      input  recarga,
      output vedacao_concluida,
      output atuador_vedacao,
      output alarme_rolha,
      output alerta_baixo,
      output contagem_rolhas
   );
endinterface

// File: rtl/fsm_vedacao.sv
// Sealing station slave FSM: times the actuator for each request and keeps the cork stock.
// Outputs are registered from next-state values, so they track the state registers exactly.
module fsm_vedacao #(
   parameter int TEMPO_VEDACAO  = 25000000,
   parameter int ROLHAS_INICIAL = 10,
   parameter int ROLHAS_MAX     = 99,
   parameter int RECARGA_QTD    = 5,
   parameter int LIMIAR_BAIXO   = 2
) (
   input  logic         clk,
   input  logic         reset,
   fsm_vedacao_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEM_ROLHA = 2'd1,
      VEDANDO   = 2'd2,
      CONCLUIDO = 2'd3
   } estado_t;

   localparam logic [25:0] TIMER_FIM   = 26'(TEMPO_VEDACAO - 1);
   localparam logic [7:0]  RECARGA_8   = 8'(RECARGA_QTD);
   localparam logic [7:0]  MAX_8       = 8'(ROLHAS_MAX);
   localparam logic [6:0]  INICIAL_7   = 7'(ROLHAS_INICIAL);
   localparam logic [6:0]  LIMIAR_7    = 7'(LIMIAR_BAIXO);

   estado_t     estado_reg,  estado_next;
   logic [25:0] timer_reg,   timer_next;
   logic [6:0]  estoque_reg, estoque_next;
   logic        dec;
   logic [7:0]  soma;

   always_comb begin
      estado_next = estado_reg;
      timer_next  = timer_reg;
      dec         = 1'b0;
      case (estado_reg)
         IDLE: begin
            timer_next = '0;
            if (bus.cmd_vedar) begin
               estado_next = (estoque_reg != 7'd0) ? VEDANDO : SEM_ROLHA;
            end
         end
         SEM_ROLHA: begin
            timer_next = '0;
            if (!bus.cmd_vedar) begin
               estado_next = IDLE;
            end else if (estoque_reg != 7'd0) begin
               estado_next = VEDANDO;
            end
         end
         VEDANDO: begin
            // A dropped request aborts without consuming a cork.
            if (!bus.cmd_vedar) begin
               estado_next = IDLE;
               timer_next  = '0;
            end else if (timer_reg == TIMER_FIM) begin
               estado_next = CONCLUIDO;
               timer_next  = '0;
               dec         = 1'b1;
            end else begin
               timer_next = timer_reg + 26'd1;
            end
         end
         CONCLUIDO: begin
            timer_next = '0;
            if (!bus.cmd_vedar) begin
               estado_next = IDLE;
            end
         end
         default: begin
            estado_next = IDLE;
            timer_next  = '0;
         end
      endcase
   end

   // Refill and decrement may coincide; sum in 8 bits so the ceiling clamp sees any overflow.
   always_comb begin
      soma = {1'b0, estoque_reg} - {7'd0, dec} + (bus.recarga ? RECARGA_8 : 8'd0);
      estoque_next = (soma > MAX_8) ? MAX_8[6:0] : soma[6:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         estado_reg            <= IDLE;
         timer_reg             <= '0;
         estoque_reg           <= INICIAL_7;
         bus.vedacao_concluida <= 1'b0;
         bus.atuador_vedacao   <= 1'b0;
         bus.alarme_rolha      <= (INICIAL_7 == 7'd0);
         bus.alerta_baixo      <= (INICIAL_7 != 7'd0) && (INICIAL_7 <= LIMIAR_7);
         bus.contagem_rolhas   <= INICIAL_7;
      end else begin
         estado_reg            <= estado_next;
         timer_reg             <= timer_next;
         estoque_reg           <= estoque_next;
         bus.vedacao_concluida <= (estado_next == CONCLUIDO);
         bus.atuador_vedacao   <= (estado_next == VEDANDO);
         bus.alarme_rolha      <= (estoque_next == 7'd0);
         bus.alerta_baixo      <= (estoque_next != 7'd0) && (estoque_next <= LIMIAR_7);
         bus.contagem_rolhas   <= estoque_next;
      end
   end

endmodule
